trap_sequencer: RTL and testbench
=================================

TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-002 Inputs SHALL be:
- timer_irq  in  1  level timer interrupt
- ext_irq  in  1  level external interrupt
- mie_global  in  1  mstatus.MIE
- mtie  in  1  timer interrupt enable
- meie  in  1  external interrupt enable
- ex_valid  in  1  valid instruction in EX
- is_mret  in  1  EX instruction is MRET
- pc_ex  in  32  PC of EX instruction
- mtvec  in  32  trap vector CSR
- mepc  in  32  current mepc CSR
REQ-003 Outputs SHALL be:
- stall_o  out  1  freeze IF/ID
- flush_o  out  1  squash IF/ID/EX
- redirect_o  out  1  load redirect_pc_o into PC
- redirect_pc_o  out  32  new PC
- trap_wr_o  out  1  write mepc/mcause
- mepc_wr_o  out  32  mepc write data
- mcause_wr_o  out  32  mcause write data
- mie_clr_o  out  1  clear mstatus.MIE
- mie_restore_o  out  1  restore mstatus.MIE from MPIE
- busy_o  out  1  state != IDLE

Function
REQ-004 pending SHALL equal mie_global & ((ext_irq & meie) | (timer_irq & mtie)).
REQ-005 The FSM SHALL have five states: IDLE, DRAIN, COMMIT, REDIRECT and MRET.
REQ-006 In IDLE, when pending & ex_valid, the block SHALL latch pc_ex and the cause, then go to DRAIN.
REQ-007 Cause priority SHALL be: external (11) over timer (7).
REQ-008 In IDLE, pending with ex_valid=0 SHALL hold IDLE with no output asserted; a precise PC is required.
REQ-009 In IDLE, when ex_valid & is_mret & !pending, the FSM SHALL go to MRET.
REQ-010 When an MRET and an interrupt occur in the same cycle, the trap SHALL win, and mepc SHALL capture the MRET's PC.
REQ-011 In DRAIN, stall_o=1 and flush_o=1 for one cycle; next state COMMIT.
REQ-012 In COMMIT, trap_wr_o=1, mie_clr_o=1 and stall_o=1 for one cycle, with:
- mepc_wr_o = {pc_q[31:2],2'b00}
- mcause_wr_o = 0x8000000B (external) or 0x80000007 (timer)
- next state REDIRECT.
REQ-013 In REDIRECT, redirect_o=1, flush_o=1 and redirect_pc_o=target for one cycle; next state IDLE.
REQ-014 In MRET, redirect_o=1, flush_o=1, mie_restore_o=1 and redirect_pc_o={mepc[31:2],2'b00} for one cycle; next state IDLE.
REQ-015 Trap latency SHALL be: capture edge at cycle N, DRAIN at N+1, trap_wr_o at N+2, redirect_o at N+3; MRET redirect_o at N+1.
REQ-016 Outside IDLE, new pending, is_mret and ex_valid SHALL be ignored; IRQ deassertion after capture SHALL NOT abort the sequence, and the latched cause SHALL be used.
REQ-017 Outputs SHALL be decoded from the state and latched registers only, with no combinational path from irq inputs to outputs.
REQ-018 Outside their asserting state, all strobe outputs SHALL be 0 and data outputs 32'h0.
REQ-019 busy_o SHALL be 1 in every state except IDLE.

Reset
REQ-020 When rst_n=0, the FSM SHALL go to IDLE asynchronously, pc_q and cause_q SHALL clear to 0, and all outputs SHALL be 0.
REQ-021 Reset asserted mid-sequence SHALL abandon it: no trap_wr_o or redirect_o after release until a new capture.

Configuration
REQ-022 With TRAP_VECTORED_EN defined and mtvec[1:0]==2'b01, target SHALL be {mtvec[31:2],2'b00} + (cause<<2); otherwise target SHALL be {mtvec[31:2],2'b00}.
REQ-023 With TRAP_VECTORED_EN undefined, target SHALL always be {mtvec[31:2],2'b00}, and mtvec[1:0] SHALL be ignored.

Verification
REQ-024 Timer IRQ: timer_irq=1, mtie=1, mie_global=1, ex_valid=1, pc_ex=0x100, mtvec=0x200 -> trap_wr_o at N+2 with mepc 0x100 and mcause 0x80000007; redirect_o to 0x200 at N+3.
REQ-025 Both IRQs: ext_irq and timer_irq asserted together -> mcause_wr_o=0x8000000B.
REQ-026 Vectored mode: mtvec=0x201, ext_irq, TRAP_VECTORED_EN defined -> redirect_pc_o=0x22C; with the macro undefined -> 0x200.
REQ-027 MRET: is_mret=1, ex_valid=1, mepc=0x104, no IRQ -> redirect_o, mie_restore_o and flush_o at N+1 with PC 0x104; trap_wr_o stays 0.
REQ-028 Gating and reset: pending with ex_valid=0 -> no outputs asserted; rst_n pulsed low in DRAIN -> busy_o=0 immediately, and no trap_wr_o or redirect_o follows.

Source files
------------

// File: rtl/trap_sequencer_if.sv
// Trap sequencer bus: groups the interrupt/pipeline inputs and the trap control
// outputs of trap_sequencer.
//   master : pipeline/CSR side, drives IRQ, EX and CSR values, receives controls
//   slave  : the sequencer itself
interface trap_sequencer_if;
    // Interrupt and pipeline status
    logic        timer_irq;
    logic        ext_irq;
    logic        mie_global;
    logic        mtie;
    logic        meie;
    logic        ex_valid;
    logic        is_mret;
    logic [31:0] pc_ex;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    // Sequencer controls
    logic        stall_o;
    logic        flush_o;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        trap_wr_o;
    logic [31:0] mepc_wr_o;
    logic [31:0] mcause_wr_o;
    logic        mie_clr_o;
    logic        mie_restore_o;
    logic        busy_o;

    modport master (
        output timer_irq, ext_irq, mie_global, mtie, meie, ex_valid, is_mret,
               pc_ex, mtvec, mepc,
        input  stall_o, flush_o, redirect_o, redirect_pc_o, trap_wr_o, mepc_wr_o,
               mcause_wr_o, mie_clr_o, mie_restore_o, busy_o
    );

    modport slave (
        input  timer_irq, ext_irq, mie_global, mtie, meie, ex_valid, is_mret,
               pc_ex, mtvec, mepc,
        output stall_o, flush_o, redirect_o, redirect_pc_o, trap_wr_o, mepc_wr_o,
               mcause_wr_o, mie_clr_o, mie_restore_o, busy_o
    );
endinterface

// File: rtl/trap_sequencer.sv
// Machine-mode interrupt entry / MRET sequencer.
// On an enabled interrupt with a valid EX instruction it captures the precise PC
// and cause, then walks DRAIN -> COMMIT (write mepc/mcause, clear MIE) ->
// REDIRECT (jump to trap vector). An MRET in EX redirects to mepc and restores MIE.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : trap_sequencer_if.slave (IRQ/EX/CSR inputs, stall/flush/redirect/CSR-write outputs)
// Configuration:
//   TRAP_VECTORED_EN : when defined, mtvec[1:0]==2'b01 selects vectored mode
//                      (target = base + cause*4); otherwise target is always the base.
module trap_sequencer (
    input logic             clk,
    input logic             rst_n,
    trap_sequencer_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StDrain, StCommit, StRedirect, StMret} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q;
    logic [3:0]  cause_q;
    logic [3:0]  cause_sel;
    logic        ext_en, tmr_en, pending, capture;
    logic [31:0] base, target;
    logic        unused_low_bits;

    assign ext_en    = bus.ext_irq & bus.meie;
    assign tmr_en    = bus.timer_irq & bus.mtie;
    assign pending   = bus.mie_global & (ext_en | tmr_en);
    assign capture   = (state_q == StIdle) & pending & bus.ex_valid;
    assign cause_sel = ext_en ? 4'd11 : 4'd7;
    assign base      = {bus.mtvec[31:2], 2'b00};

`ifdef TRAP_VECTORED_EN
    assign target = (bus.mtvec[1:0] == 2'b01) ? base + {26'd0, cause_q, 2'b00} : base;
`else
    assign target = base;
`endif

    // Low address bits are forced to zero on every PC output.
    assign unused_low_bits = ^{bus.mtvec[1:0], bus.mepc[1:0], pc_q[1:0]};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Captured PC and cause; only loaded on a trap capture in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= 32'h0;
            cause_q <= 4'h0;
        end else if (capture) begin
            pc_q    <= bus.pc_ex;
            cause_q <= cause_sel;
        end
    end

    // Next state: a trap takes precedence over a coincident MRET.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (capture) begin
                    state_d = StDrain;
                end else if (bus.ex_valid && bus.is_mret) begin
                    state_d = StMret;
                end
            end
            StDrain:    state_d = StCommit;
            StCommit:   state_d = StRedirect;
            StRedirect: state_d = StIdle;
            StMret:     state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // Outputs depend only on state and captured registers (plus CSR values).
    always_comb begin
        bus.stall_o       = 1'b0;
        bus.flush_o       = 1'b0;
        bus.redirect_o    = 1'b0;
        bus.redirect_pc_o = 32'h0;
        bus.trap_wr_o     = 1'b0;
        bus.mepc_wr_o     = 32'h0;
        bus.mcause_wr_o   = 32'h0;
        bus.mie_clr_o     = 1'b0;
        bus.mie_restore_o = 1'b0;
        bus.busy_o        = (state_q != StIdle);
        unique case (state_q)
            StDrain: begin
                bus.stall_o = 1'b1;
                bus.flush_o = 1'b1;
            end
            StCommit: begin
                bus.stall_o     = 1'b1;
                bus.trap_wr_o   = 1'b1;
                bus.mie_clr_o   = 1'b1;
                bus.mepc_wr_o   = {pc_q[31:2], 2'b00};
                bus.mcause_wr_o = {1'b1, 27'd0, cause_q};
            end
            StRedirect: begin
                bus.redirect_o    = 1'b1;
                bus.flush_o       = 1'b1;
                bus.redirect_pc_o = target;
            end
            StMret: begin
                bus.redirect_o    = 1'b1;
                bus.flush_o       = 1'b1;
                bus.mie_restore_o = 1'b1;
                bus.redirect_pc_o = {bus.mepc[31:2], 2'b00};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed self-checking bench for trap_sequencer.
// Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
module tb_trap_sequencer;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    trap_sequencer_if bus ();

    trap_sequencer dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {stall, flush, redirect, trap_wr, mie_clr, mie_restore, busy}
    logic [6:0]  ctl;
    // {redirect_pc, mepc_wr, mcause_wr}
    logic [95:0] dat;
    assign ctl = {bus.stall_o, bus.flush_o, bus.redirect_o, bus.trap_wr_o, bus.mie_clr_o,
                  bus.mie_restore_o, bus.busy_o};
    assign dat = {bus.redirect_pc_o, bus.mepc_wr_o, bus.mcause_wr_o};

    localparam logic [6:0] CtlIdle   = 7'b0000000;
    localparam logic [6:0] CtlDrain  = 7'b1100001;
    localparam logic [6:0] CtlCommit = 7'b1001101;
    localparam logic [6:0] CtlRedir  = 7'b0110001;
    localparam logic [6:0] CtlMret   = 7'b0110011;

    task automatic clear_inputs();
        bus.timer_irq  = 1'b0;
        bus.ext_irq    = 1'b0;
        bus.mie_global = 1'b0;
        bus.mtie       = 1'b0;
        bus.meie       = 1'b0;
        bus.ex_valid   = 1'b0;
        bus.is_mret    = 1'b0;
        bus.pc_ex      = 32'h0;
        bus.mtvec      = 32'h0;
        bus.mepc       = 32'h0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        // Pending interrupt while held in reset must not start anything.
        bus.timer_irq = 1'b1; bus.mtie = 1'b1; bus.mie_global = 1'b1; bus.ex_valid = 1'b1;
        bus.pc_ex = 32'h100; bus.mtvec = 32'h200;
        step();
        step();
        checks++;
        if ({ctl, dat} !== {CtlIdle, 96'h0}) begin
            errors++;
            $display("FAIL reset_outputs got ctl=%b dat=%h want ctl=%b dat=0", ctl, dat, CtlIdle);
        end
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;
        step();
        checks++;
        if (ctl !== CtlIdle) begin
            errors++;
            $display("FAIL reset_release_idle got %b want %b", ctl, CtlIdle);
        end
    endtask

    task automatic test_timer();
        @(negedge clk);
        bus.timer_irq = 1'b1; bus.mtie = 1'b1; bus.mie_global = 1'b1; bus.ex_valid = 1'b1;
        bus.pc_ex = 32'h100; bus.mtvec = 32'h200;
        #1;
        // Still IDLE before the capture edge: no combinational IRQ path.
        checks++;
        if ({ctl, dat} !== {CtlIdle, 96'h0}) begin
            errors++;
            $display("FAIL timer_pre_edge got ctl=%b dat=%h want idle/0", ctl, dat);
        end
        step();
        checks++;
        if ({ctl, dat} !== {CtlDrain, 96'h0}) begin
            errors++;
            $display("FAIL timer_drain got ctl=%b dat=%h want ctl=%b dat=0", ctl, dat, CtlDrain);
        end
        // IRQ drops and EX changes after capture; sequence must continue with latched values.
        @(negedge clk);
        bus.timer_irq = 1'b0; bus.pc_ex = 32'h500; bus.is_mret = 1'b1;
        step();
        checks++;
        if ({ctl, dat} !== {CtlCommit, 32'h0, 32'h100, 32'h8000_0007}) begin
            errors++;
            $display("FAIL timer_commit got ctl=%b dat=%h want ctl=%b pc=0 mepc=100 mcause=80000007",
                     ctl, dat, CtlCommit);
        end
        step();
        checks++;
        if ({ctl, dat} !== {CtlRedir, 32'h200, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL timer_redirect got ctl=%b dat=%h want ctl=%b pc=200", ctl, dat, CtlRedir);
        end
        @(negedge clk);
        clear_inputs();
        step();
        checks++;
        if ({ctl, dat} !== {CtlIdle, 96'h0}) begin
            errors++;
            $display("FAIL timer_back_idle got ctl=%b dat=%h want idle/0", ctl, dat);
        end
    endtask

    task automatic test_both_irqs();
        @(negedge clk);
        bus.timer_irq = 1'b1; bus.ext_irq = 1'b1; bus.mtie = 1'b1; bus.meie = 1'b1;
        bus.mie_global = 1'b1; bus.ex_valid = 1'b1; bus.pc_ex = 32'h0000_1236;
        bus.mtvec = 32'h400;
        step();
        // While busy, drop external and keep timer: latched cause must stay external.
        @(negedge clk);
        bus.ext_irq = 1'b0;
        step();
        checks++;
        if ({ctl, dat} !== {CtlCommit, 32'h0, 32'h0000_1234, 32'h8000_000B}) begin
            errors++;
            $display("FAIL both_commit got ctl=%b dat=%h want mepc=1234 mcause=8000000b",
                     ctl, dat);
        end
        step();
        checks++;
        if (bus.redirect_pc_o !== 32'h400) begin
            errors++;
            $display("FAIL both_redirect_pc got %h want 00000400", bus.redirect_pc_o);
        end
        @(negedge clk);
        clear_inputs();
        step();
    endtask

    task automatic test_vectored();
        logic [31:0] exp_pc;
`ifdef TRAP_VECTORED_EN
        exp_pc = 32'h22C;
`else
        exp_pc = 32'h200;
`endif
        @(negedge clk);
        bus.ext_irq = 1'b1; bus.meie = 1'b1; bus.mie_global = 1'b1; bus.ex_valid = 1'b1;
        bus.pc_ex = 32'h80; bus.mtvec = 32'h201;
        step();
        @(negedge clk);
        bus.ext_irq = 1'b0;
        step();
        step();
        checks++;
        if ({ctl, bus.redirect_pc_o} !== {CtlRedir, exp_pc}) begin
            errors++;
            $display("FAIL vectored_redirect got ctl=%b pc=%h want ctl=%b pc=%h",
                     ctl, bus.redirect_pc_o, CtlRedir, exp_pc);
        end
        @(negedge clk);
        clear_inputs();
        step();
    endtask

    task automatic test_mret();
        @(negedge clk);
        bus.is_mret = 1'b1; bus.ex_valid = 1'b1; bus.mepc = 32'h104; bus.mie_global = 1'b0;
        step();
        checks++;
        if ({ctl, dat} !== {CtlMret, 32'h104, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL mret_redirect got ctl=%b dat=%h want ctl=%b pc=104", ctl, dat, CtlMret);
        end
        @(negedge clk);
        bus.is_mret = 1'b0; bus.ex_valid = 1'b0;
        step();
        checks++;
        if ({ctl, dat} !== {CtlIdle, 96'h0}) begin
            errors++;
            $display("FAIL mret_back_idle got ctl=%b dat=%h want idle/0", ctl, dat);
        end
        // Misaligned mepc is forced to word alignment.
        @(negedge clk);
        bus.is_mret = 1'b1; bus.ex_valid = 1'b1; bus.mepc = 32'h0000_2007;
        step();
        checks++;
        if (bus.redirect_pc_o !== 32'h0000_2004) begin
            errors++;
            $display("FAIL mret_align got %h want 00002004", bus.redirect_pc_o);
        end
        @(negedge clk);
        clear_inputs();
        step();
    endtask

    task automatic test_mret_vs_irq();
        @(negedge clk);
        bus.is_mret = 1'b1; bus.ex_valid = 1'b1; bus.mepc = 32'h104;
        bus.timer_irq = 1'b1; bus.mtie = 1'b1; bus.mie_global = 1'b1;
        bus.pc_ex = 32'h300; bus.mtvec = 32'h600;
        step();
        checks++;
        if (ctl !== CtlDrain) begin
            errors++;
            $display("FAIL mret_irq_drain got %b want %b", ctl, CtlDrain);
        end
        step();
        checks++;
        if ({ctl, dat} !== {CtlCommit, 32'h0, 32'h300, 32'h8000_0007}) begin
            errors++;
            $display("FAIL mret_irq_commit got ctl=%b dat=%h want mepc=300 mcause=80000007",
                     ctl, dat);
        end
        step();
        checks++;
        if ({ctl, bus.redirect_pc_o} !== {CtlRedir, 32'h600}) begin
            errors++;
            $display("FAIL mret_irq_redirect got ctl=%b pc=%h want ctl=%b pc=600",
                     ctl, bus.redirect_pc_o, CtlRedir);
        end
        @(negedge clk);
        clear_inputs();
        step();
    endtask

    task automatic test_gating();
        // Pending without a valid EX instruction: stay idle.
        @(negedge clk);
        bus.timer_irq = 1'b1; bus.ext_irq = 1'b1; bus.mtie = 1'b1; bus.meie = 1'b1;
        bus.mie_global = 1'b1; bus.ex_valid = 1'b0; bus.pc_ex = 32'h700; bus.mtvec = 32'h800;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({ctl, dat} !== {CtlIdle, 96'h0}) begin
                errors++;
                $display("FAIL gate_no_ex cycle %0d got ctl=%b dat=%h want idle/0", i, ctl, dat);
            end
        end
        // Globally disabled.
        @(negedge clk);
        bus.ex_valid = 1'b1; bus.mie_global = 1'b0;
        step();
        checks++;
        if (ctl !== CtlIdle) begin
            errors++;
            $display("FAIL gate_mie_global got %b want %b", ctl, CtlIdle);
        end
        // Individually disabled sources.
        @(negedge clk);
        bus.mie_global = 1'b1; bus.mtie = 1'b0; bus.meie = 1'b0;
        step();
        checks++;
        if (ctl !== CtlIdle) begin
            errors++;
            $display("FAIL gate_source_en got %b want %b", ctl, CtlIdle);
        end
        @(negedge clk);
        clear_inputs();
        step();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.ext_irq = 1'b1; bus.meie = 1'b1; bus.mie_global = 1'b1; bus.ex_valid = 1'b1;
        bus.pc_ex = 32'h900; bus.mtvec = 32'hA00;
        step();
        checks++;
        if (ctl !== CtlDrain) begin
            errors++;
            $display("FAIL rst_mid_drain got %b want %b", ctl, CtlDrain);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ctl, dat} !== {CtlIdle, 96'h0}) begin
            errors++;
            $display("FAIL rst_mid_async got ctl=%b dat=%h want idle/0", ctl, dat);
        end
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({ctl, dat} !== {CtlIdle, 96'h0}) begin
                errors++;
                $display("FAIL rst_mid_after cycle %0d got ctl=%b dat=%h want idle/0",
                         i, ctl, dat);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_timer();
        test_both_irqs();
        test_vectored();
        test_mret();
        test_mret_vs_irq();
        test_gating();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
